// File: rtl/axil_pattern_master.sv
// AXI4-Lite bring-up master: writes NUM_TXN pattern words to a strided window,
// reads them back and reports a sticky error flag, a count and the first failing address.
module axil_pattern_master #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_TXN     = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    ADDR_STRIDE = 4
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic                      INIT_AXI_TXN,
    input  logic [1:0]                MODE,
    input  logic [1:0]                PATTERN,
    input  logic [DATA_WIDTH-1:0]     SEED,
    output logic                      BUSY,
    output logic                      TXN_DONE,
    output logic                      ERROR,
    output logic [15:0]               ERR_COUNT,
    output logic [ADDR_WIDTH-1:0]     ERR_ADDR,
    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                M_AXI_AWPROT,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                M_AXI_ARPROT,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);
    localparam int                    IDX_W    = (NUM_TXN > 1) ? $clog2(NUM_TXN) : 1;
    localparam int                    SH_W     = $clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_TXN - 1);
    localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(ADDR_STRIDE);
    localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

    state_t                  state_reg, state_next;
    logic                    init_reg, start_pulse_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [1:0]              mode_reg, pattern_reg;
    logic [DATA_WIDTH-1:0]   seed_reg;
    logic                    aw_done_reg, w_done_reg;
    logic                    error_reg;
    logic [15:0]             err_count_reg;
    logic [ADDR_WIDTH-1:0]   err_addr_reg;

    logic                    start, advance, beat_err, last;
    logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [DATA_WIDTH-1:0]   word_sum, pattern_word;

    assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID  & M_AXI_WREADY;
    assign b_hs  = M_AXI_BVALID  & M_AXI_BREADY;
    assign ar_hs = M_AXI_ARVALID & M_AXI_ARREADY;
    assign r_hs  = M_AXI_RVALID  & M_AXI_RREADY;
    assign last  = (idx_reg == LAST_IDX);

    // Write data and expected read data come from the same function of the index.
    always_comb begin
        word_sum = seed_reg + DATA_WIDTH'(idx_reg);
        case (pattern_reg)
            2'd0:    pattern_word = word_sum;
            2'd1:    pattern_word = ONE << SH_W'(idx_reg);
            2'd2:    pattern_word = ~word_sum;
            default: pattern_word = DATA_WIDTH'(addr_reg);
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        advance    = 1'b0;
        beat_err   = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start_pulse_reg) begin
                    start      = 1'b1;
                    state_next = (MODE == 2'd2) ? RD_REQ : WR_REQ;
                end
            end
            WR_REQ: begin
                if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    advance  = 1'b1;
                    beat_err = (M_AXI_BRESP != 2'b00);
                    if (last) begin
                        state_next = (mode_reg == 2'd1) ? DONE : RD_REQ;
                    end else begin
                        state_next = WR_REQ;
                    end
                end
            end
            RD_REQ: begin
                if (ar_hs) begin
                    state_next = RD_RESP;
                end
            end
            RD_RESP: begin
                if (r_hs) begin
                    advance    = 1'b1;
                    beat_err   = (M_AXI_RRESP != 2'b00) || (M_AXI_RDATA != pattern_word);
                    state_next = last ? DONE : RD_REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // init_reg resets high so an INIT held through reset is not seen as an edge.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            init_reg        <= 1'b1;
            start_pulse_reg <= 1'b0;
            idx_reg         <= '0;
            addr_reg        <= '0;
            mode_reg        <= 2'd0;
            pattern_reg     <= 2'd0;
            seed_reg        <= '0;
            aw_done_reg     <= 1'b0;
            w_done_reg      <= 1'b0;
            error_reg       <= 1'b0;
            err_count_reg   <= 16'd0;
            err_addr_reg    <= '0;
        end else begin
            init_reg        <= INIT_AXI_TXN;
            start_pulse_reg <= INIT_AXI_TXN & ~init_reg;
            if (start) begin
                mode_reg      <= MODE;
                pattern_reg   <= PATTERN;
                seed_reg      <= SEED;
                idx_reg       <= '0;
                addr_reg      <= BASE_ADDR;
                aw_done_reg   <= 1'b0;
                w_done_reg    <= 1'b0;
                error_reg     <= 1'b0;
                err_count_reg <= 16'd0;
                err_addr_reg  <= '0;
            end else begin
                if (state_reg == WR_REQ) begin
                    aw_done_reg <= (state_next == WR_REQ) && (aw_done_reg || aw_hs);
                    w_done_reg  <= (state_next == WR_REQ) && (w_done_reg || w_hs);
                end
                if (beat_err) begin
                    error_reg <= 1'b1;
                    if (err_count_reg != 16'hFFFF) begin
                        err_count_reg <= err_count_reg + 16'd1;
                    end
                    if (!error_reg) begin
                        err_addr_reg <= addr_reg;
                    end
                end
                if (advance) begin
                    if (last) begin
                        idx_reg  <= '0;
                        addr_reg <= BASE_ADDR;
                    end else begin
                        idx_reg  <= idx_reg + 1'b1;
                        addr_reg <= addr_reg + STRIDE;
                    end
                end
            end
        end
    end

    assign BUSY          = (state_reg != IDLE) && (state_reg != DONE);
    assign TXN_DONE      = (state_reg == DONE);
    assign ERROR         = error_reg;
    assign ERR_COUNT     = err_count_reg;
    assign ERR_ADDR      = err_addr_reg;

    assign M_AXI_AWVALID = (state_reg == WR_REQ) && !aw_done_reg;
    assign M_AXI_WVALID  = (state_reg == WR_REQ) && !w_done_reg;
    assign M_AXI_AWADDR  = (state_reg == WR_REQ) ? addr_reg : '0;
    assign M_AXI_WDATA   = (state_reg == WR_REQ) ? pattern_word : '0;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_BREADY  = (state_reg == WR_RESP);
    assign M_AXI_ARVALID = (state_reg == RD_REQ);
    assign M_AXI_ARADDR  = (state_reg == RD_REQ) ? addr_reg : '0;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_RREADY  = (state_reg == RD_RESP);

endmodule
